// File: rtl/status_msg_scheduler.sv
// Status/event message scheduler: latches event rises, arbitrates by fixed
// priority, shows each message for HOLD_CYCLES, then a blank GAP_CYCLES gap.
module status_msg_scheduler #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned BEEP_CYCLES = 12_500_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       reset_button,
  input  logic       on,
  input  logic       off,
  input  logic       err,
  input  logic       open,
  input  logic       buzz,
  output logic [2:0] msg_code,
  output logic       msg_valid,
  output logic [4:0] grant,
  output logic       buzzer_en,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [2:0] CODE_ERR  = 3'd3;
  localparam logic [2:0] CODE_BUZZ = 3'd5;

  state_t           r_state, w_state_nx;
  logic [4:0]       r_prev, r_pend, w_pend_nx, w_ev, w_rise, w_sel, w_grant_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, r_bcnt, w_bcnt_nx;
  logic [2:0]       r_code, w_code_nx, w_sel_code;
  logic             r_valid, w_valid_nx, r_buzz, w_buzz_nx, r_arm, w_load;
  logic [4:0]       r_grant;

  assign w_ev = {buzz, open, err, off, on};

  // r_arm masks the first post-reset cycle so levels held through reset
  // are sampled into r_prev instead of being seen as rises.
  assign w_rise = r_arm ? (w_ev & ~r_prev) : '0;

  always_comb begin
    w_sel      = '0;
    w_sel_code = '0;
    if (r_pend[2]) begin
      w_sel = 5'b00100; w_sel_code = 3'd3;
    end else if (r_pend[3]) begin
      w_sel = 5'b01000; w_sel_code = 3'd4;
    end else if (r_pend[4]) begin
      w_sel = 5'b10000; w_sel_code = 3'd5;
    end else if (r_pend[0]) begin
      w_sel = 5'b00001; w_sel_code = 3'd1;
    end else if (r_pend[1]) begin
      w_sel = 5'b00010; w_sel_code = 3'd2;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bcnt_nx  = r_bcnt;
    w_pend_nx  = r_pend | w_rise;
    w_code_nx  = r_code;
    w_valid_nx = r_valid;
    w_grant_nx = '0;
    w_buzz_nx  = r_buzz;
    w_load     = 1'b0;

    case (r_state)
      IDLE: w_load = (r_pend != '0);
      SHOW: begin
        if (r_pend[2] && (r_code != CODE_ERR)) begin
          w_load = 1'b1;
        end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          w_state_nx = GAP;
          w_cnt_nx   = '0;
          w_code_nx  = '0;
          w_valid_nx = 1'b0;
          w_buzz_nx  = 1'b0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
          if (r_code == CODE_ERR) begin
            if (r_bcnt == CNT_W'(BEEP_CYCLES - 1)) begin
              w_bcnt_nx = '0;
              w_buzz_nx = ~r_buzz;
            end else begin
              w_bcnt_nx = r_bcnt + 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    // A rise of the granted event in the same cycle re-arms it.
    if (w_load) begin
      w_state_nx = SHOW;
      w_pend_nx  = (r_pend & ~w_sel) | w_rise;
      w_code_nx  = w_sel_code;
      w_valid_nx = 1'b1;
      w_grant_nx = w_sel;
      w_cnt_nx   = '0;
      w_bcnt_nx  = '0;
      w_buzz_nx  = (w_sel_code == CODE_ERR) || (w_sel_code == CODE_BUZZ);
    end

    if (reset_button) begin
      w_state_nx = IDLE;
      w_pend_nx  = '0;
      w_code_nx  = '0;
      w_valid_nx = 1'b0;
      w_grant_nx = '0;
      w_buzz_nx  = 1'b0;
      w_cnt_nx   = '0;
      w_bcnt_nx  = '0;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_buzz  <= 1'b0;
      r_arm   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_prev  <= w_ev;
      r_pend  <= w_pend_nx;
      r_cnt   <= w_cnt_nx;
      r_bcnt  <= w_bcnt_nx;
      r_code  <= w_code_nx;
      r_valid <= w_valid_nx;
      r_grant <= w_grant_nx;
      r_buzz  <= w_buzz_nx;
      r_arm   <= 1'b1;
    end
  end

  assign msg_code  = r_code;
  assign msg_valid = r_valid;
  assign grant     = r_grant;
  assign buzzer_en = r_buzz;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_status_msg_scheduler.sv
// Directed bench for status_msg_scheduler with short timing parameters
// (HOLD=8, GAP=2, BEEP=2); table vectors plus multi-cycle sequences.
module tb_status_msg_scheduler;

  logic       clk = 1'b0;
  logic       reset, reset_button;
  logic [4:0] ev;  // {buzz,open,err,off,on}
  logic [2:0] msg_code;
  logic       msg_valid, buzzer_en, busy;
  logic [4:0] grant;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  status_msg_scheduler #(
    .HOLD_CYCLES(8),
    .GAP_CYCLES (2),
    .BEEP_CYCLES(2),
    .CNT_W      (4)
  ) dut (
    .clk_50MHz   (clk),
    .reset       (reset),
    .reset_button(reset_button),
    .on          (ev[0]),
    .off         (ev[1]),
    .err         (ev[2]),
    .open        (ev[3]),
    .buzz        (ev[4]),
    .msg_code    (msg_code),
    .msg_valid   (msg_valid),
    .grant       (grant),
    .buzzer_en   (buzzer_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rb;
    logic [4:0] ev;
    logic [2:0] code;
    logic       valid;
    logic [4:0] grant;
    logic       buzz;
    logic       busy;
  } vec_t;

  vec_t tbl[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string nm, input logic [2:0] c, input logic v,
                            input logic [4:0] g, input logic bz, input logic by);
    chk({nm, ".code"},  int'(msg_code),  int'(c));
    chk({nm, ".valid"}, int'(msg_valid), int'(v));
    chk({nm, ".grant"}, int'(grant),     int'(g));
    chk({nm, ".buzz"},  int'(buzzer_en), int'(bz));
    chk({nm, ".busy"},  int'(busy),      int'(by));
  endtask

  // Steps through a full message from its load edge: 8 show cycles,
  // 2 gap cycles, 1 idle cycle.
  task automatic expect_msg(input string nm, input logic [2:0] c, input logic [4:0] g);
    logic bz;
    for (int k = 0; k < 8; k++) begin
      step();
      bz = (c == 3'd3) ? (((k / 2) % 2) == 0) : (c == 3'd5);
      expect_out({nm, ".show"}, c, 1'b1, (k == 0) ? g : 5'b0, bz, 1'b1);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      expect_out({nm, ".gap"}, 3'd0, 1'b0, 5'b0, 1'b0, 1'b1);
    end
    step();
    expect_out({nm, ".idle"}, 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with events high, release, single ON pulse through one full message.
    for (int i = 0; i < 3; i++)  tbl[i] = '{1'b1, 1'b0, 5'h1F, 3'd0, 1'b0, 5'b0, 1'b0, 1'b0};
    for (int i = 3; i < 6; i++)  tbl[i] = '{1'b0, 1'b0, 5'h1F, 3'd0, 1'b0, 5'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 5'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 5'h01, 3'd0, 1'b0, 5'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 5'h00, 3'd1, 1'b1, 5'b00001, 1'b0, 1'b1};
    for (int i = 9; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 5'h00, 3'd1, 1'b1, 5'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 5'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 5'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 5'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 5'b0, 1'b0, 1'b0};

    reset = 1'b1; reset_button = 1'b0; ev = '0;
    #1;
    for (int i = 0; i < 20; i++) begin
      reset = tbl[i].rst; reset_button = tbl[i].rb; ev = tbl[i].ev;
      step();
      expect_out($sformatf("tbl%0d", i), tbl[i].code, tbl[i].valid, tbl[i].grant,
                 tbl[i].buzz, tbl[i].busy);
    end

    // Simultaneous ON/OFF/ERR rises served in priority order.
    ev = 5'b00111; step();
    expect_out("simul.latch", 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);
    ev = '0;
    expect_msg("simul.err", 3'd3, 5'b00100);
    expect_msg("simul.on",  3'd1, 5'b00001);
    expect_msg("simul.off", 3'd2, 5'b00010);
    step();
    expect_out("simul.done", 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);

    // ERR preempts ON in its fourth show cycle; ON is dropped.
    ev = 5'b00001; step();
    ev = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out("pre.on", 3'd1, 1'b1, (k == 0) ? 5'b00001 : 5'b0, 1'b0, 1'b1);
    end
    ev = 5'b00100; step();
    expect_out("pre.on3", 3'd1, 1'b1, 5'b0, 1'b0, 1'b1);
    expect_msg("pre.err", 3'd3, 5'b00100);
    ev = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_out("pre.after", 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);
    end

    // BUZZ: buzzer held high for the whole show window.
    ev = 5'b10000; step();
    ev = '0;
    expect_msg("buzz", 3'd5, 5'b10000);

    // reset_button mid-OPEN with ON pending clears everything.
    ev = 5'b01000; step();
    ev = '0; step();
    expect_out("rb.open0", 3'd4, 1'b1, 5'b01000, 1'b0, 1'b1);
    ev = 5'b00001; step();
    ev = '0; step(); step();
    expect_out("rb.open3", 3'd4, 1'b1, 5'b0, 1'b0, 1'b1);
    reset_button = 1'b1; step();
    expect_out("rb.clear", 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);
    reset_button = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      expect_out("rb.quiet", 3'd0, 1'b0, 5'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
